game_flow_ctrl: RTL and testbench

Session controller for the runner game. It debounces the player inputs and merges them with the Bluetooth pulses into clean start/jump events. It sequences the game core through idle, countdown, play and game-over by driving the core's reset and jump inputs, and it keeps score and high score for the HEX displays. It sits between the board keys / Bluetooth receiver and the game core, and consumes the core's `game_alive` flag.

---
 rtl/game_flow_ctrl_if.sv | 34 +++
 rtl/game_flow_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl_if
// Brief    : Signal bundle between the keys/Bluetooth/game core and the
//            session controller.
// Revision : 1.0
// ============================================================================
interface game_flow_ctrl_if;
  logic       start_key_n;
  logic       jump_key_n;
  logic       bt_start;
  logic       bt_jump;
  logic       game_alive;
  logic       core_rst_n;
  logic       jump_out;
  logic [2:0] state;
  logic [7:0] score_bcd;
  logic [7:0] hi_bcd;
  logic [6:0] hex0;
  logic [6:0] hex1;

  // Controller side.
  modport slave (
    input  start_key_n, jump_key_n, bt_start, bt_jump, game_alive,
    output core_rst_n, jump_out, state, score_bcd, hi_bcd, hex0, hex1
  );

  // Board / core side.
  modport master (
    output start_key_n, jump_key_n, bt_start, bt_jump, game_alive,
    input  core_rst_n, jump_out, state, score_bcd, hi_bcd, hex0, hex1
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl
// Brief    : Runner-game session controller: input conditioning, session FSM,
//            score / high score and HEX display drive.
// Revision : 1.0
// ============================================================================
module game_flow_ctrl #(
  parameter int TICK_DIV        = 524288,
  parameter int DEBOUNCE_CYC    = 500000,
  parameter int COUNTDOWN_TICKS = 96,
  parameter int SCORE_TICKS     = 48,
  parameter int JUMP_COOLDOWN   = 1024
) (
  input wire              clk,
  input wire              reset_n,
  game_flow_ctrl_if.slave ctrl_if
);

  localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int c_CD_W   = (COUNTDOWN_TICKS > 1) ? $clog2(COUNTDOWN_TICKS) : 1;
  localparam int c_SC_W   = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
  localparam int c_COOL_W = $clog2(JUMP_COOLDOWN + 1);

  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_OVER      = 3'd3
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = c_SEG_BLANK;
    endcase
    return s;
  endfunction

  // Countdown shows 3, 2, 1 across three equal thirds of the countdown.
  function automatic logic [3:0] cd_digit(input logic [c_CD_W-1:0] cd);
    int prod;
    prod = 3 * int'(cd);
    if (prod < COUNTDOWN_TICKS)          return 4'd3;
    else if (prod < 2 * COUNTDOWN_TICKS) return 4'd2;
    else                                 return 4'd1;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)        return v;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // ---------------------------------------------------------------- tick
  logic [c_TICK_W-1:0] tick_cnt_q;
  logic                w_tick;

  assign w_tick = (tick_cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    tick_cnt_q <= '0;
    else if (tick_cnt_q == c_TICK_W'(TICK_DIV - 1))  tick_cnt_q <= '0;
    else                                             tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------- keys
  // Index 0 = start key, index 1 = jump key.
  logic [1:0] w_key_raw;
  logic [1:0] w_key_press;

  assign w_key_raw = {ctrl_if.jump_key_n, ctrl_if.start_key_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    logic               sync1_q;
    logic               sync2_q;
    logic               deb_q;
    logic               deb_prev_q;
    logic               press_q;
    logic [c_DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        deb_q      <= 1'b1;
        deb_prev_q <= 1'b1;
        press_q    <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= w_key_raw[gi];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        press_q    <= deb_prev_q & ~deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == c_DEB_W'(DEBOUNCE_CYC - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_key_press[gi] = press_q;
  end

  // ----------------------------------------------------------- bluetooth
  logic bt_start_prev_q;
  logic bt_jump_prev_q;
  logic bt_start_edge_q;
  logic bt_jump_edge_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bt_start_prev_q <= 1'b0;
      bt_jump_prev_q  <= 1'b0;
      bt_start_edge_q <= 1'b0;
      bt_jump_edge_q  <= 1'b0;
    end else begin
      bt_start_prev_q <= ctrl_if.bt_start;
      bt_jump_prev_q  <= ctrl_if.bt_jump;
      bt_start_edge_q <= ctrl_if.bt_start & ~bt_start_prev_q;
      bt_jump_edge_q  <= ctrl_if.bt_jump & ~bt_jump_prev_q;
    end
  end

  logic w_start_evt;
  logic w_jump_evt;

  assign w_start_evt = w_key_press[0] | bt_start_edge_q;
  assign w_jump_evt  = w_key_press[1] | bt_jump_edge_q;

  // ----------------------------------------------------------------- FSM
  state_t              state_q,      state_d;
  logic [c_CD_W-1:0]   cd_q,         cd_d;
  logic [c_SC_W-1:0]   sc_cnt_q,     sc_cnt_d;
  logic [7:0]          score_q,      score_d;
  logic [7:0]          hi_q,         hi_d;
  logic [c_COOL_W-1:0] cool_q,       cool_d;
  logic                jump_q,       jump_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic [6:0]          hex0_q,       hex0_d;
  logic [6:0]          hex1_q,       hex1_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cd_q         <= '0;
      sc_cnt_q     <= '0;
      score_q      <= 8'h00;
      hi_q         <= 8'h00;
      cool_q       <= '0;
      jump_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      hex0_q       <= c_SEG_DASH;
      hex1_q       <= c_SEG_DASH;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      sc_cnt_q     <= sc_cnt_d;
      score_q      <= score_d;
      hi_q         <= hi_d;
      cool_q       <= cool_d;
      jump_q       <= jump_d;
      core_rst_n_q <= core_rst_n_d;
      hex0_q       <= hex0_d;
      hex1_q       <= hex1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    sc_cnt_d = sc_cnt_q;
    score_d  = score_q;
    hi_d     = hi_q;
    jump_d   = 1'b0;
    cool_d   = (cool_q != '0) ? cool_q - 1'b1 : cool_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (w_start_evt) begin
          state_d  = ST_COUNTDOWN;
          cd_d     = '0;
          sc_cnt_d = '0;
          score_d  = 8'h00;
        end
      end
      ST_COUNTDOWN: begin
        if (w_tick) begin
          if (cd_q == c_CD_W'(COUNTDOWN_TICKS - 1)) state_d = ST_PLAY;
          else                                      cd_d    = cd_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_jump_evt && (cool_q == '0)) begin
          jump_d = 1'b1;
          cool_d = c_COOL_W'(JUMP_COOLDOWN);
        end
        // A collision pre-empts any score tick in the same cycle.
        if (!ctrl_if.game_alive) begin
          state_d = ST_OVER;
          if (score_q > hi_q) hi_d = score_q;
        end else if (w_tick) begin
          if (sc_cnt_q == c_SC_W'(SCORE_TICKS - 1)) begin
            sc_cnt_d = '0;
            score_d  = bcd_inc(score_q);
          end else begin
            sc_cnt_d = sc_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_rst_n_d = (state_d == ST_PLAY) || (state_d == ST_OVER);

    // Display follows the next state so it lines up with the state output.
    hex0_d = c_SEG_DASH;
    hex1_d = c_SEG_DASH;
    case (state_d)
      ST_COUNTDOWN: begin
        hex0_d = seg7(cd_digit(cd_d));
        hex1_d = c_SEG_BLANK;
      end
      ST_PLAY, ST_OVER: begin
        hex0_d = seg7(score_d[3:0]);
        hex1_d = seg7(score_d[7:4]);
      end
      default: ;
    endcase
  end

  assign ctrl_if.state      = state_q;
  assign ctrl_if.core_rst_n = core_rst_n_q;
  assign ctrl_if.jump_out   = jump_q;
  assign ctrl_if.score_bcd  = score_q;
  assign ctrl_if.hi_bcd     = hi_q;
  assign ctrl_if.hex0       = hex0_q;
  assign ctrl_if.hex1       = hex1_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_ctrl
// Brief    : Directed bench for game_flow_ctrl with a behavioural session model.
// Revision : 1.0
// ============================================================================
module tb_game_flow_ctrl;

  localparam int TICK_DIV        = 16;
  localparam int DEBOUNCE_CYC    = 4;
  localparam int COUNTDOWN_TICKS = 6;
  localparam int SCORE_TICKS     = 2;
  localparam int JUMP_COOLDOWN   = 8;

  localparam int IDLE = 0, CD = 1, PLAY = 2, OVER = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic chk_en  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_jumps  = 0;

  game_flow_ctrl_if dut_if ();

  game_flow_ctrl #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYC    (DEBOUNCE_CYC),
    .COUNTDOWN_TICKS (COUNTDOWN_TICKS),
    .SCORE_TICKS     (SCORE_TICKS),
    .JUMP_COOLDOWN   (JUMP_COOLDOWN)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl_if (dut_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Segment pattern from the lit-segment set of each digit, inverted for active-low.
  function automatic int seg(input int d);
    int lit [0:9];
    lit = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    return (~lit[d]) & 'h7F;
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // ------------------------------------------------------ behavioural model
  int m_state, m_score, m_hi, m_cd, m_sct, m_cool, m_tick;
  bit m_jump;
  bit k_s1 [2], k_s2 [2], k_deb [2], k_prev [2], k_press [2];
  int k_cnt [2];
  bit bt_prev [2], bt_edge [2];
  bit m_tk, m_sev, m_jev;
  bit raw_k [2], raw_b [2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = IDLE; m_score = 0; m_hi = 0; m_cd = 0; m_sct = 0;
      m_cool = 0; m_tick = 0; m_jump = 0;
      for (int i = 0; i < 2; i++) begin
        k_s1[i] = 1; k_s2[i] = 1; k_deb[i] = 1; k_prev[i] = 1; k_press[i] = 0;
        k_cnt[i] = 0; bt_prev[i] = 0; bt_edge[i] = 0;
      end
    end else begin
      m_tk   = (m_tick == 0);
      m_tick = (m_tick + 1) % TICK_DIV;
      m_sev  = k_press[0] || bt_edge[0];
      m_jev  = k_press[1] || bt_edge[1];

      m_jump = (m_state == PLAY) && m_jev && (m_cool == 0);
      if (m_jump)          m_cool = JUMP_COOLDOWN;
      else if (m_cool > 0) m_cool = m_cool - 1;

      case (m_state)
        IDLE, OVER: if (m_sev) begin
          m_state = CD; m_score = 0; m_cd = 0; m_sct = 0;
        end
        CD: if (m_tk) begin
          if (m_cd == COUNTDOWN_TICKS - 1) m_state = PLAY;
          else                             m_cd = m_cd + 1;
        end
        PLAY: begin
          if (!dut_if.game_alive) begin
            m_state = OVER;
            if (m_score > m_hi) m_hi = m_score;
          end else if (m_tk) begin
            m_sct = m_sct + 1;
            if (m_sct == SCORE_TICKS) begin
              m_sct = 0;
              if (m_score < 99) m_score = m_score + 1;
            end
          end
        end
        default: ;
      endcase

      raw_k[0] = dut_if.start_key_n; raw_k[1] = dut_if.jump_key_n;
      raw_b[0] = dut_if.bt_start;    raw_b[1] = dut_if.bt_jump;
      for (int i = 0; i < 2; i++) begin
        k_press[i] = k_prev[i] && !k_deb[i];
        k_prev[i]  = k_deb[i];
        if (k_s2[i] == k_deb[i]) k_cnt[i] = 0;
        else begin
          k_cnt[i] = k_cnt[i] + 1;
          if (k_cnt[i] == DEBOUNCE_CYC) begin
            k_deb[i] = k_s2[i];
            k_cnt[i] = 0;
          end
        end
        k_s2[i]    = k_s1[i];
        k_s1[i]    = raw_k[i];
        bt_edge[i] = raw_b[i] && !bt_prev[i];
        bt_prev[i] = raw_b[i];
      end
    end
  end

  // ---------------------------------------------------- per-cycle compare
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("state",      int'(dut_if.state),      m_state);
      check("core_rst_n", int'(dut_if.core_rst_n), (m_state == PLAY || m_state == OVER) ? 1 : 0);
      check("jump_out",   int'(dut_if.jump_out),   int'(m_jump));
      check("score_bcd",  int'(dut_if.score_bcd),  to_bcd(m_score));
      check("hi_bcd",     int'(dut_if.hi_bcd),     to_bcd(m_hi));
      case (m_state)
        IDLE: begin
          check("hex0", int'(dut_if.hex0), 'h3F);
          check("hex1", int'(dut_if.hex1), 'h3F);
        end
        CD: begin
          check("hex0", int'(dut_if.hex0), seg(3 - (m_cd * 3) / COUNTDOWN_TICKS));
          check("hex1", int'(dut_if.hex1), 'h7F);
        end
        default: begin
          check("hex0", int'(dut_if.hex0), seg(m_score % 10));
          check("hex1", int'(dut_if.hex1), seg(m_score / 10));
        end
      endcase
    end
    if (reset_n && dut_if.jump_out === 1'b1) n_jumps++;
  end

  // ------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(dut_if.state) != s && n < budget) begin
      step(1);
      n++;
    end
    check(name, int'(dut_if.state), s);
  endtask

  task automatic pulse_bt_start();
    dut_if.bt_start = 1'b1;
    step(1);
    dut_if.bt_start = 1'b0;
  endtask

  task automatic pulse_bt_jump();
    dut_if.bt_jump = 1'b1;
    step(1);
    dut_if.bt_jump = 1'b0;
  endtask

  task automatic die();
    dut_if.game_alive = 1'b0;
    step(1);
    dut_if.game_alive = 1'b1;
  endtask

  logic [6:0] seen [$];
  int j0;

  initial begin
    dut_if.start_key_n = 1'b1;
    dut_if.jump_key_n  = 1'b1;
    dut_if.bt_start    = 1'b0;
    dut_if.bt_jump     = 1'b0;
    dut_if.game_alive  = 1'b1;
    reset_n = 1'b0;
    step(3);

    check("rst_state",    int'(dut_if.state),      0);
    check("rst_core_rst", int'(dut_if.core_rst_n), 0);
    check("rst_jump",     int'(dut_if.jump_out),   0);
    check("rst_score",    int'(dut_if.score_bcd),  0);
    check("rst_hi",       int'(dut_if.hi_bcd),     0);
    check("rst_hex0",     int'(dut_if.hex0),       'h3F);
    check("rst_hex1",     int'(dut_if.hex1),       'h3F);

    reset_n = 1'b1;
    chk_en  = 1'b1;
    step(2);

    // Jump request in IDLE is ignored.
    j0 = n_jumps;
    pulse_bt_jump();
    step(6);
    check("idle_jump_count", n_jumps - j0, 0);

    // Start via Bluetooth: COUNTDOWN two cycles after the pulse.
    dut_if.bt_start = 1'b1;
    step(1);
    check("start_not_yet", int'(dut_if.state), 0);
    dut_if.bt_start = 1'b0;
    step(1);
    check("start_state", int'(dut_if.state), 1);
    check("cd_hex1",     int'(dut_if.hex1),  'h7F);

    seen.delete();
    seen.push_back(dut_if.hex0);
    for (int n = 0; n < 200 && int'(dut_if.state) == 1; n++) begin
      step(1);
      if (int'(dut_if.state) == 1 && dut_if.hex0 != seen[$]) seen.push_back(dut_if.hex0);
    end
    check("cd_to_play",   int'(dut_if.state), 2);
    check("cd_seq_len",   seen.size(), 3);
    check("cd_digit3",    (seen.size() > 0) ? int'(seen[0]) : 0, 'h30);
    check("cd_digit2",    (seen.size() > 1) ? int'(seen[1]) : 0, 'h24);
    check("cd_digit1",    (seen.size() > 2) ? int'(seen[2]) : 0, 'h79);
    check("play_core_rst", int'(dut_if.core_rst_n), 1);

    // Bluetooth jump latency: pulse at N, jump_out at N+2.
    dut_if.bt_jump = 1'b1;
    step(1);
    check("bt_lat_n1", int'(dut_if.jump_out), 0);
    dut_if.bt_jump = 1'b0;
    step(1);
    check("bt_lat_n2", int'(dut_if.jump_out), 1);
    step(12);

    // Debounce: 3-cycle press is rejected.
    j0 = n_jumps;
    dut_if.jump_key_n = 1'b0; step(3); dut_if.jump_key_n = 1'b1; step(12);
    check("key_short_count", n_jumps - j0, 0);

    // 8-cycle press gives one pulse.
    j0 = n_jumps;
    dut_if.jump_key_n = 1'b0; step(8); dut_if.jump_key_n = 1'b1; step(12);
    check("key_long_count", n_jumps - j0, 1);

    // One-cycle glitch high while held gives no second pulse.
    j0 = n_jumps;
    dut_if.jump_key_n = 1'b0; step(8);
    dut_if.jump_key_n = 1'b1; step(1);
    dut_if.jump_key_n = 1'b0; step(6);
    dut_if.jump_key_n = 1'b1; step(14);
    check("key_glitch_count", n_jumps - j0, 1);

    // Cooldown: pulses 4 apart -> one; 10 apart -> two.
    j0 = n_jumps;
    pulse_bt_jump(); step(3); pulse_bt_jump(); step(12);
    check("cool_4_count", n_jumps - j0, 1);
    j0 = n_jumps;
    pulse_bt_jump(); step(9); pulse_bt_jump(); step(12);
    check("cool_10_count", n_jumps - j0, 2);

    // Key press and Bluetooth jump landing in the same cycle -> one pulse.
    j0 = n_jumps;
    dut_if.jump_key_n = 1'b0; step(6);
    pulse_bt_jump(); step(1);
    dut_if.jump_key_n = 1'b1; step(14);
    check("merge_count", n_jumps - j0, 1);

    // First game ends early.
    die();
    step(2);
    check("game1_over", int'(dut_if.state), 3);

    // Second game via the start key; die at 24 ticks -> 12.
    dut_if.start_key_n = 1'b0; step(8); dut_if.start_key_n = 1'b1;
    wait_state(2, 200, "game2_play");
    step(386);
    check("score_24_ticks", int'(dut_if.score_bcd), 'h12);
    die();
    check("game2_over",  int'(dut_if.state),     3);
    check("game2_hi",    int'(dut_if.hi_bcd),    'h12);

    // Third game: die at 05 with a simultaneous start request.
    pulse_bt_start();
    wait_state(2, 200, "game3_play");
    step(164);
    check("score_10_ticks", int'(dut_if.score_bcd), 'h05);
    dut_if.bt_start = 1'b1;
    step(1);
    dut_if.bt_start   = 1'b0;
    dut_if.game_alive = 1'b0;
    step(1);
    dut_if.game_alive = 1'b1;
    step(4);
    check("start_vs_over", int'(dut_if.state),     3);
    check("game3_score",   int'(dut_if.score_bcd), 'h05);
    check("game3_hi",      int'(dut_if.hi_bcd),    'h12);

    // Fourth game: saturation at 99.
    pulse_bt_start();
    wait_state(2, 200, "game4_play");
    step(250 * TICK_DIV + 4);
    check("score_sat", int'(dut_if.score_bcd), 'h99);
    die();
    step(2);

    // Reset in the middle of a countdown.
    pulse_bt_start();
    step(20);
    check("pre_rst_state", int'(dut_if.state), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state",    int'(dut_if.state),      0);
    check("arst_core_rst", int'(dut_if.core_rst_n), 0);
    check("arst_jump",     int'(dut_if.jump_out),   0);
    check("arst_score",    int'(dut_if.score_bcd),  0);
    check("arst_hi",       int'(dut_if.hi_bcd),     0);
    check("arst_hex0",     int'(dut_if.hex0),       'h3F);
    check("arst_hex1",     int'(dut_if.hex1),       'h3F);
    step(2);
    reset_n = 1'b1;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
